// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-adder cell (two half adders + OR) stepped
// LSB first, one bit per clock, with the result and a done strobe registered at the end.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_out_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] s_sh_q;
    logic             c_q;
    logic [CntW-1:0]  cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_out_q;

    logic             ha1_s;
    logic             ha1_c;
    logic             ha2_c;
    logic             step_s;
    logic             step_c;
    logic [WIDTH-1:0] s_sh_step;

    // Shared cell: first half adder on the operand bits, second folds in the carry.
    always_comb begin
        ha1_s  = a_sh_q[0] ^ b_sh_q[0];
        ha1_c  = a_sh_q[0] & b_sh_q[0];
        step_s = ha1_s ^ c_q;
        ha2_c  = ha1_s & c_q;
        step_c = ha1_c | ha2_c;
    end

    // New sum bit enters at the MSB so that after WIDTH steps bit 0 holds the first result.
    always_comb begin
        s_sh_step            = s_sh_q >> 1;
        s_sh_step[WIDTH-1]   = step_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            s_sh_q      <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_sh_q  <= a_i;
                        b_sh_q  <= b_i;
                        c_q     <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    s_sh_q <= s_sh_step;
                    c_q    <= step_c;
                    cnt_q  <= cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        sum_q       <= s_sh_step;
                        carry_out_q <= step_c;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign sum_o       = sum_q;
    assign carry_out_o = carry_out_q;

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial WIDTH-bit adder controller that time-shares a single one-bit adder cell across all bit positions, one bit per clock. The cell is two half adders plus an OR for carry. The block accepts an operand pair on a start pulse, sequences the LSB-first bit steps through the shared cell with a registered carry, then presents the registered sum and carry-out with a one-cycle done strobe. It sits between a requester (bench or upstream control) and the half-adder/full-adder datapath. It replaces a WIDTH-wide ripple adder where area matters more than latency.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal range WIDTH >= 1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle strobe; sum and carry_out are valid from this cycle onward.
- sum  output  WIDTH  registered result (a + b) mod 2^WIDTH.
- carry_out  output  1  registered carry out of bit WIDTH-1.

## Operation
- Reset (async, rst=1): state=IDLE; busy=0, done=0, sum=0, carry_out=0; internal shift registers, carry and bit counter all 0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - load a_sh<=a and b_sh<=b;
  - set c<=0 and cnt<=0;
  - go to RUN.
- IDLE, start=0: stay in IDLE; outputs hold.
- RUN, each edge: compute one bit step.
  - s = a_sh[0] ^ b_sh[0] ^ c
  - c <= (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]))
  - a_sh and b_sh shift right one bit.
  - s shifts into the MSB of internal s_sh, which also shifts right.
  - cnt <= cnt + 1.
- RUN exit: on the edge where cnt == WIDTH-1:
  - sum <= final s_sh, including this step's bit;
  - carry_out <= this step's carry;
  - go to DONE.
- DONE: done=1 for exactly this cycle; next edge returns to IDLE unconditionally.
- start is ignored in RUN and DONE. It is not queued. A start held high is re-accepted at the first IDLE edge.
- sum and carry_out change only on the RUN→DONE edge and on reset. They hold between operations. They never show partial results.
- Counter width is max(1, clog2(WIDTH)) bits. Wrap-around is not reachable.
- a and b may change freely after the accepting edge without affecting the result.

## Timing
- Accepting edge E0 (IDLE, start=1): busy=1 after E0.
- Bit i (LSB first) is processed at edge E(i+1), for i = 0 .. WIDTH-1.
- At edge E(WIDTH): busy=0, done=1, sum and carry_out update.
- At edge E(WIDTH+1): done=0, state=IDLE. The earliest next acceptance is E(WIDTH+2).
- Latency from start acceptance to done is WIDTH cycles. Throughput is one result per WIDTH+2 cycles with start held high.
- WIDTH=1: RUN lasts one edge; done rises at E1.
- Reset asserted mid-RUN or in DONE:
  - immediately, without waiting for a clock edge, busy=0, done=0, sum=0, carry_out=0;
  - the operation in flight is discarded;
  - after rst deasserts, the first edge with start=1 begins a fresh operation.
- busy and done are never high together.

## Test plan
- Reset, then a=0x00, b=0x00, start pulse at E0 -> busy high E0..E8, done at E8 only, sum=0x00, carry_out=0.
- a=0x5A, b=0x3C, start at E0 -> at E8: sum=0x96, carry_out=0; sum is unchanged at E1..E7 from its previous value.
- a=0xFF, b=0x01 -> sum=0x00, carry_out=1. Then a=0xFF, b=0xFF -> sum=0xFE, carry_out=1.
- Start a=0x10, b=0x20. Pulse start with a=0xAA, b=0x55 at E3 and at E8 (DONE) -> both ignored; result sum=0x30, carry_out=0; no second done.
- start held high continuously with fixed a=0x01, b=0x02 -> done at E8, E18, E28; sum=0x03 each time; busy low exactly during each DONE cycle and IDLE cycle.
- Start a=0xF0, b=0x0F, assert rst mid-cycle after E4 -> sum=0, carry_out=0, busy=0 without a clock edge. Release rst, start a=0x01, b=0x01 -> sum=0x02 eight cycles later.
